// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - alu_ctrl opcodes and EX-stage ALU state encoding
package mips_alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;
    localparam logic [3:0] ALU_MFHI  = 4'b1010;
    localparam logic [3:0] ALU_MFLO  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/mips_muldiv_seq.sv
// rtl/mips_muldiv_seq.sv - iterative unsigned shift-add multiply / restoring divide, one bit per cycle
// The divide datapath exists only when MIPS_ALU_DIV_EN is defined.
module mips_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             running_q, running_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc, mul_q;
    logic [WIDTH-1:0] step_acc, step_q;

    // {acc, q} shifts right; q starts as the multiplier and ends as the low product half
    always_comb begin
        mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_acc = mul_sum[WIDTH:1];
        mul_q   = {mul_sum[0], q_q[WIDTH-1:1]};
    end

`ifdef MIPS_ALU_DIV_EN
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_acc, div_q;

    // With b == 0 every step subtracts nothing: quotient all ones, remainder ends as a
    always_comb begin
        div_shift = {acc_q, q_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift - {1'b0, b_q};
        div_acc   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_q     = {q_q[WIDTH-2:0], div_ge};
    end

    assign step_acc = op_q ? div_acc : mul_acc;
    assign step_q   = op_q ? div_q   : mul_q;
`else
    logic unused_op_q;
    assign unused_op_q = op_q;
    assign step_acc    = mul_acc;
    assign step_q      = mul_q;
`endif

    always_comb begin
        running_d = running_q;
        op_d      = op_q;
        acc_d     = acc_q;
        q_d       = q_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        if (start) begin
            running_d = 1'b1;
            op_d      = op;
            acc_d     = '0;
            q_d       = a;
            b_d       = b;
            cnt_d     = '0;
        end else if (running_q) begin
            acc_d = step_acc;
            q_d   = step_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                running_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            op_q      <= 1'b0;
            acc_q     <= '0;
            q_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
        end else begin
            running_q <= running_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
        end
    end

    // The final iteration is handed over combinationally so HI/LO land on that same edge
    assign done = running_q && (cnt_q == LAST);
    assign hi   = step_acc;
    assign lo   = step_q;

endmodule

// File: rtl/mips_alu_seq.sv
// rtl/mips_alu_seq.sv - registered EX-stage MIPS ALU with handshake, HI/LO and iterative MULTU/DIVU
// DIVU is built only when MIPS_ALU_DIV_EN is defined; otherwise code 1001 is illegal.
module mips_alu_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);
    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             out_valid_q, out_valid_d;

    logic             md_start, md_op, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] diff, sc_result;
    logic             slt_bit;

    mips_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (md_op),
        .a     (a),
        .b     (b),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // Differing signs decide SLT directly, so an overflowing a-b cannot flip the answer
    always_comb begin
        diff      = a - b;
        slt_bit   = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : diff[WIDTH-1];
        sc_result = '0;
        case (alu_ctrl)
            ALU_AND:  sc_result = a & b;
            ALU_OR:   sc_result = a | b;
            ALU_ADD:  sc_result = a + b;
            ALU_SUB:  sc_result = diff;
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, slt_bit};
            ALU_NOR:  sc_result = ~(a | b);
            ALU_MFHI: sc_result = hi_q;
            ALU_MFLO: sc_result = lo_q;
            default:  sc_result = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        out_valid_d = 1'b0;
        md_start    = 1'b0;
        md_op       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    case (alu_ctrl)
                        ALU_MULTU: begin
                            state_d  = MUL;
                            md_start = 1'b1;
                        end
`ifdef MIPS_ALU_DIV_EN
                        ALU_DIVU: begin
                            state_d  = DIV;
                            md_start = 1'b1;
                            md_op    = 1'b1;
                        end
`endif
                        default: begin
                            result_d    = sc_result;
                            out_valid_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL, DIV: begin
                if (md_done) begin
                    state_d     = IDLE;
                    hi_d        = md_hi;
                    lo_d        = md_lo;
                    result_d    = md_lo;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_mips_alu_seq.sv
// tb/tb_mips_alu_seq.sv - scoreboard bench for mips_alu_seq at WIDTH 32 and 8 (honours MIPS_ALU_DIV_EN)
module tb_mips_alu_seq;
    import mips_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv, ir, ov, z, bsy;
    logic [3:0]  ctrl;
    logic [31:0] a, b, res;
    logic        iv8, ir8, ov8, z8, bsy8;
    logic [3:0]  ctrl8;
    logic [7:0]  a8, b8, res8;

    always #5 clk = ~clk;

    mips_alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .alu_ctrl(ctrl),
        .a(a), .b(b), .out_valid(ov), .result(res), .zero(z), .busy(bsy)
    );

    mips_alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .alu_ctrl(ctrl8),
        .a(a8), .b(b8), .out_valid(ov8), .result(res8), .zero(z8), .busy(bsy8)
    );

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t m32, m8;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   w;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", nm, act, exp);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest expectation, including its cycle
    always @(negedge clk) begin
        if (ov) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid32 got result %0h required no output", res);
            end else begin
                m32 = q32.pop_front();
                chk({m32.name, "_result"}, {32'd0, res}, {32'd0, m32.res});
                chk({m32.name, "_zero"}, {63'd0, z}, {63'd0, m32.z});
                chk({m32.name, "_cycle"}, 64'(cyc), 64'(m32.cyc));
            end
        end
        if (ov8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid8 got result %0h required no output", res8);
            end else begin
                m8 = q8.pop_front();
                chk({m8.name, "_result"}, {56'd0, res8}, {32'd0, m8.res});
                chk({m8.name, "_zero"}, {63'd0, z8}, {63'd0, m8.z});
                chk({m8.name, "_cycle"}, 64'(cyc), 64'(m8.cyc));
            end
        end
    end

    // Drive at a negedge once in_ready is seen; acceptance happens on the following posedge
    task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] er, input int lat, input string nm, output int waited);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!ir && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ir) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout got in_ready 0 required 1", nm);
        end
        iv = 1'b1; ctrl = c; a = x; b = y;
        e.res = er; e.z = (er == 32'd0); e.cyc = cyc + 1 + lat; e.name = nm;
        q32.push_back(e);
        waited = n;
    endtask

    task automatic issue8(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] er, input int lat, input string nm, output int waited);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!ir8 && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ir8) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout got in_ready 0 required 1", nm);
        end
        iv8 = 1'b1; ctrl8 = c; a8 = x; b8 = y;
        e.res = {24'd0, er}; e.z = (er == 8'd0); e.cyc = cyc + 1 + lat; e.name = nm;
        q8.push_back(e);
        waited = n;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        iv = 1'b0; iv8 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain32_pending", 64'(q32.size()), 64'd0);
        chk("drain8_pending", 64'(q8.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish required finish before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        iv = 1'b0; ctrl = 4'd0; a = '0; b = '0;
        iv8 = 1'b0; ctrl8 = 4'd0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, ir}, 64'd1);
        chk("rst_busy", {63'd0, bsy}, 64'd0);
        chk("rst_out_valid", {63'd0, ov}, 64'd0);
        chk("rst_result", {32'd0, res}, 64'd0);
        chk("rst_zero", {63'd0, z}, 64'd1);
        rst_n = 1'b1;

        issue(ALU_AND, 32'h19, 32'h3D, 32'h19, 0, "and", w);
        issue(ALU_NOR, 32'h19, 32'h3D, 32'hFFFFFFC2, 0, "nor", w);
        chk("nor_back_to_back_wait", 64'(w), 64'd0);
        issue(ALU_OR, 32'h19, 32'h3D, 32'h3D, 0, "or", w);
        issue(ALU_ADD, 32'hFFFFFFFF, 32'h2, 32'h1, 0, "add_wrap", w);
        issue(ALU_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 0, "sub_0_1", w);
        issue(ALU_SLT, 32'h80000000, 32'h1, 32'h1, 0, "slt_neg_pos", w);
        issue(ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 32'h0, 0, "slt_ovf", w);
        issue(ALU_SUB, 32'h5, 32'h5, 32'h0, 0, "sub_5_5", w);
        issue(4'b0011, 32'h5, 32'h7, 32'h0, 0, "illegal", w);

        // in_valid stays high with MULTU while busy; a re-acceptance would show as an extra pulse
        issue(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32, "multu", w);
        issue(ALU_MFHI, 32'h0, 32'h0, 32'hFFFFFFFE, 0, "mfhi_mul", w);
        chk("multu_ready_low_cycles", 64'(w), 64'd32);
        issue(ALU_MFLO, 32'h0, 32'h0, 32'h1, 0, "mflo_mul", w);
`ifdef MIPS_ALU_DIV_EN
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 32, "divu_100_7", w);
        issue(ALU_MFHI, 32'h0, 32'h0, 32'd2, 0, "mfhi_div", w);
        chk("divu_ready_low_cycles", 64'(w), 64'd32);
        issue(ALU_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 32, "divu_by_zero", w);
        issue(ALU_MFHI, 32'h0, 32'h0, 32'd9, 0, "mfhi_div0", w);
        issue(ALU_MFLO, 32'h0, 32'h0, 32'hFFFFFFFF, 0, "mflo_div0", w);
`else
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd0, 0, "divu_disabled", w);
        issue(ALU_MFHI, 32'h0, 32'h0, 32'hFFFFFFFE, 0, "mfhi_nodiv", w);
        chk("divu_disabled_wait", 64'(w), 64'd0);
        issue(ALU_MFLO, 32'h0, 32'h0, 32'h1, 0, "mflo_nodiv", w);
`endif
        idle(2);
        drain();

        // Reset during MULTU: no out_valid, HI/LO cleared
        @(negedge clk);
        iv = 1'b1; ctrl = ALU_MULTU; a = 32'hFFFFFFFF; b = 32'h3;
        @(negedge clk);
        iv = 1'b0;
        chk("abort_busy_before_reset", {63'd0, bsy}, 64'd1);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready_in_reset", {63'd0, ir}, 64'd1);
        chk("abort_busy_in_reset", {63'd0, bsy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready_after", {63'd0, ir}, 64'd1);
        issue(ALU_MFHI, 32'h0, 32'h0, 32'h0, 0, "mfhi_after_abort", w);
        issue(ALU_MFLO, 32'h0, 32'h0, 32'h0, 0, "mflo_after_abort", w);
        idle(40);

        issue8(ALU_MULTU, 8'd200, 8'd200, 8'h40, 8, "w8_multu", w);
        issue8(ALU_MFHI, 8'h0, 8'h0, 8'h9C, 0, "w8_mfhi", w);
        chk("w8_ready_low_cycles", 64'(w), 64'd8);
        issue8(ALU_MFLO, 8'h0, 8'h0, 8'h40, 0, "w8_mflo", w);
        idle(3);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_alu_seq.md
# mips_alu_seq

Parametrised, registered successor to the single-cycle MIPS ALU. It adds a valid/ready input handshake, registered outputs, and an iterative unsigned multiply/divide unit with architectural HI/LO registers, which enables MULTU/DIVU/MFHI/MFLO. It sits in the EX stage of the multi-cycle MIPS datapath, between operand latches and the writeback mux.

## Interface
- WIDTH, 32, operand/result width in bits; minimum 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  high when the block can accept an operation.
- alu_ctrl  input  4  operation code.
- a, b  input  WIDTH  operands.
- out_valid  output  1  one-cycle pulse; result and zero are valid.
- result  output  WIDTH  registered result.
- zero  output  1  high when result == 0.
- busy  output  1  multiply/divide in progress.

## Operation
- Codes:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD (wraps, no overflow trap).
  - 0110 SUB (wraps).
  - 0111 SLT: signed a<b gives 1, else 0. The result is correct when a-b overflows (compare the sign bits first).
  - 1100 NOR.
  - 1000 MULTU: {HI,LO} = a*b, 2*WIDTH-bit unsigned product.
  - 1001 DIVU: LO = a/b, HI = a%b, unsigned.
  - 1010 MFHI: result = HI.
  - 1011 MFLO: result = LO.
- Any other code is illegal: result 0, zero 1, HI/LO unchanged.
- An operation is accepted when in_valid && in_ready on a rising edge. Operands and code are captured on that edge.
- State machine, in_ready = (state == IDLE):
  - IDLE:
    - Accepting a single-cycle op: register result, pulse out_valid next cycle, remain in IDLE.
    - Accepting MULTU: go to MUL.
    - Accepting DIVU: go to DIV.
  - MUL: shift-add, one product bit per cycle, WIDTH iterations. Then write HI/LO, result = LO, pulse out_valid, return to IDLE.
  - DIV: restoring division, one quotient bit per cycle, WIDTH iterations. Then write HI/LO, result = LO, pulse out_valid, return to IDLE.
- Divide by zero: LO = all ones, HI = a. No exception.
- MFHI/MFLO issued directly after MULTU/DIVU sees the new HI/LO.
- zero is computed from the registered result and is meaningful only when out_valid is high.
- There is no output backpressure. The consumer must take result on the out_valid cycle.

## Timing
- Reset values:
  - state IDLE, in_ready 1, busy 0.
  - out_valid 0, result 0, zero 1.
  - HI 0, LO 0.
- Single-cycle ops: accepted on edge N, out_valid high for cycle N+1. Back-to-back acceptance every cycle.
- MULTU/DIVU: accepted on edge N.
  - busy and !in_ready for cycles N+1 through N+WIDTH.
  - out_valid in cycle N+WIDTH+1, with in_ready already 1 that cycle.
  - Initiation interval WIDTH+1.
- in_valid while !in_ready is ignored. It is not queued.
- Reset asserted mid-operation aborts immediately. All registers return to reset values, including HI/LO, and no out_valid is produced.
- A change of alu_ctrl, a or b after acceptance has no effect on the operation in flight.

## Configuration
- MIPS_ALU_DIV_EN:
  - Defined: DIVU is implemented as above.
  - Undefined: the divide datapath is not built. 1001 is treated as an illegal code (1-cycle, result 0, zero 1, HI/LO unchanged).
  - MULTU is always present.

## Structure
- Package mips_alu_pkg:
  - alu_ctrl code localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_MULTU, ALU_DIVU, ALU_MFHI, ALU_MFLO.
  - State enum IDLE/MUL/DIV.
- One sub-module, mips_muldiv_seq:
  - Contains the iterative multiply/divide engine: accumulator, shift registers, WIDTH-bit iteration counter.
  - Interface: start, op, a, b; done, hi, lo.
- The top level holds the handshake, the single-cycle datapath, HI/LO and the output registers.

## Test plan
- AND 0x19 & 0x3D gives 0x19. NOR of the same operands gives 0xFFFFFFC2, zero 0. Issue back-to-back, one out_valid per cycle.
- SUB 0-1 gives 0xFFFFFFFF. SLT a=0x80000000, b=0x00000001 gives 1. SLT a=0x7FFFFFFF, b=0x80000000 gives 0. SUB 5-5 gives zero 1.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF:
  - out_valid exactly 33 cycles after acceptance.
  - in_ready low for 32 cycles.
  - MFHI then returns 0xFFFFFFFE and MFLO returns 0x00000001.
- DIVU 100/7 gives LO 14, HI 2. DIVU 9/0 gives LO 0xFFFFFFFF, HI 9. With MIPS_ALU_DIV_EN undefined: 1-cycle, result 0, HI/LO unchanged.
- in_valid held during MULTU busy: no extra acceptance. Reset pulsed at cycle 10 of MULTU: no out_valid, HI/LO 0, in_ready 1 after release.
- WIDTH=8: MULTU 200*200 gives HI 0x9C, LO 0x40, out_valid at N+9.
